// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit
// Description : Condition/flag stage between execute and writeback. Holds the
//               architectural NZCV register, evaluates the per-instruction
//               4-bit condition code and gates the PC/register/memory write
//               requests. One valid/ready pipeline slot; flags commit when
//               the slot retires.
//
// Optional feature (macro COND_FLAG_FWD_EN):
//   defined   : the slot's pending flag update is forwarded into the
//               condition evaluation, so the stage never stalls.
//   undefined : an instruction that reads flags waits while the slot holds
//               an uncommitted flag update.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   in_valid / in_ready          upstream handshake
//   cond                         condition code (EQ..NV)
//   flag_write                   bit1 -> N,Z ; bit0 -> C,V
//   aluflags                     ALU result flags {N,Z,C,V}
//   pcs, regw, memw              requested writes
//   out_valid / out_ready        downstream handshake
//   cond_ex                      registered condition result
//   pc_src_o, reg_write_o,
//   mem_write_o                  registered requests gated by cond_ex
//   flags_q                      committed NZCV
//
// Revision    : 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
    parameter int                 FLAGS_W     = 4,
    parameter logic [FLAGS_W-1:0] RESET_FLAGS = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         cond,
    input  logic [1:0]         flag_write,
    input  logic [FLAGS_W-1:0] aluflags,
    input  logic               pcs,
    input  logic               regw,
    input  logic               memw,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               cond_ex,
    output logic               pc_src_o,
    output logic               reg_write_o,
    output logic               mem_write_o,
    output logic [FLAGS_W-1:0] flags_q
);

    localparam logic [3:0] c_COND_AL = 4'hE;
    localparam logic [3:0] c_COND_NV = 4'hF;

    logic [FLAGS_W-1:0] r_flags;
    logic               r_valid;
    logic               r_cond_ex;
    logic               r_pcs;
    logic               r_regw;
    logic               r_memw;
    logic [FLAGS_W-1:0] r_pf;
    logic [1:0]         r_pw;

    logic [FLAGS_W-1:0] w_eff_flags;
    logic               w_pending;
    logic               w_stall;
    logic               w_cond_pass;
    logic               w_accept;
    logic               w_retire;
    logic               w_n, w_z, w_c, w_v;

    assign w_pending = r_valid & (r_pw != 2'b00);

`ifdef COND_FLAG_FWD_EN
    // Merge the uncommitted update so the incoming instruction sees the
    // flags exactly as they will be once the slot retires.
    always_comb begin
        w_eff_flags = r_flags;
        if (w_pending) begin
            if (r_pw[1]) w_eff_flags[3:2] = r_pf[3:2];
            if (r_pw[0]) w_eff_flags[1:0] = r_pf[1:0];
        end
    end
    assign w_stall = 1'b0;
`else
    assign w_eff_flags = r_flags;
    // AL and NV do not depend on the flags, so they may pass a hazard.
    assign w_stall = w_pending & (cond != c_COND_AL) & (cond != c_COND_NV);
`endif

    assign in_ready = (~r_valid | out_ready) & ~w_stall;
    assign w_accept = in_valid & in_ready;
    assign w_retire = r_valid & out_ready;

    assign {w_n, w_z, w_c, w_v} = w_eff_flags;

    always_comb begin
        w_cond_pass = 1'b0;
        case (cond)
            4'h0: w_cond_pass = w_z;
            4'h1: w_cond_pass = ~w_z;
            4'h2: w_cond_pass = w_c;
            4'h3: w_cond_pass = ~w_c;
            4'h4: w_cond_pass = w_n;
            4'h5: w_cond_pass = ~w_n;
            4'h6: w_cond_pass = w_v;
            4'h7: w_cond_pass = ~w_v;
            4'h8: w_cond_pass = w_c & ~w_z;
            4'h9: w_cond_pass = ~w_c | w_z;
            4'hA: w_cond_pass = (w_n == w_v);
            4'hB: w_cond_pass = (w_n != w_v);
            4'hC: w_cond_pass = ~w_z & (w_n == w_v);
            4'hD: w_cond_pass = w_z | (w_n != w_v);
            4'hE: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // Committed flag register: written only when the slot leaves the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= RESET_FLAGS;
        end else if (w_retire) begin
            if (r_pw[1]) r_flags[3:2] <= r_pf[3:2];
            if (r_pw[0]) r_flags[1:0] <= r_pf[1:0];
        end
    end

    // Output slot. Accept has priority so retire+accept swaps with no bubble;
    // with neither, every field holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_cond_ex <= 1'b0;
            r_pcs     <= 1'b0;
            r_regw    <= 1'b0;
            r_memw    <= 1'b0;
            r_pf      <= '0;
            r_pw      <= 2'b00;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_cond_ex <= w_cond_pass;
            r_pcs     <= pcs  & w_cond_pass;
            r_regw    <= regw & w_cond_pass;
            r_memw    <= memw & w_cond_pass;
            r_pf      <= aluflags;
            r_pw      <= flag_write & {2{w_cond_pass}};
        end else if (w_retire) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign cond_ex     = r_cond_ex;
    assign pc_src_o    = r_pcs;
    assign reg_write_o = r_regw;
    assign mem_write_o = r_memw;
    assign flags_q     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_flag_unit
// Description : Self-checking bench for cond_flag_unit. Instructions are
//               judged in program order against an architectural flag model;
//               expected slot contents are queued on accept and checked by an
//               independent monitor every cycle the slot is occupied.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] cond = 4'hE;
    logic [1:0] flag_write = 2'b00;
    logic [3:0] aluflags = 4'h0;
    logic       pcs = 1'b0, regw = 1'b0, memw = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       cond_ex, pc_src_o, reg_write_o, mem_write_o;
    logic [3:0] flags_q;

    cond_flag_unit dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .flag_write(flag_write), .aluflags(aluflags),
        .pcs(pcs), .regw(regw), .memw(memw),
        .out_valid(out_valid), .out_ready(out_ready),
        .cond_ex(cond_ex), .pc_src_o(pc_src_o),
        .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
        .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ce;
        logic       p, r, m;
        logic       wr;     // instruction actually changes the flags
        logic [3:0] post;   // architectural flags after this instruction
    } entry_t;

    entry_t     sb[$];
    logic [3:0] arch_flags = 4'h0;
    logic [3:0] exp_committed = 4'h0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of each condition code, with flags {N,Z,C,V}.
    function automatic logic holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cy && !z;   4'h9: return !cy || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock of stimulus; returns whether the instruction was taken.
    task automatic cyc(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] af, input logic p, input logic r,
                       input logic m, input logic ordy, output logic acc);
        entry_t e;
        in_valid = v; cond = c; flag_write = fw; aluflags = af;
        pcs = p; regw = r; memw = m; out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready && !reset;
        @(posedge clk);
        if (acc) begin
            e.ce = holds(c, arch_flags);
            e.p = p && e.ce; e.r = r && e.ce; e.m = m && e.ce;
            e.wr = e.ce && (fw != 2'b00);
            if (e.ce) begin
                if (fw[1]) arch_flags[3:2] = af[3:2];
                if (fw[0]) arch_flags[1:0] = af[1:0];
            end
            e.post = arch_flags;
            sb.push_back(e);
        end
        #1;
    endtask

    // Present an instruction until it is taken, bounded.
    task automatic send(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                        input logic p, input logic r, input logic m);
        logic acc;
        int   k;
        acc = 1'b0;
        for (k = 0; k < 20 && !acc; k++) cyc(1'b1, c, fw, af, p, r, m, 1'b1, acc);
        if (!acc) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: cond %h never accepted", c);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    // Monitor: checks the slot against the scoreboard head every cycle.
    always @(negedge clk) begin
        logic   exp_ov, exp_ir, stall;
        entry_t h;
        exp_ov = (sb.size() != 0);
        chk("out_valid", {3'b0, out_valid}, {3'b0, exp_ov});
        chk("flags_q", flags_q, exp_committed);
        stall = 1'b0;
        if (exp_ov) begin
            h = sb[0];
            chk("cond_ex", {3'b0, cond_ex}, {3'b0, h.ce});
            chk("gated_writes", {1'b0, pc_src_o, reg_write_o, mem_write_o}, {1'b0, h.p, h.r, h.m});
`ifndef COND_FLAG_FWD_EN
            stall = h.wr && (cond != 4'hE) && (cond != 4'hF);
`endif
            exp_ir = out_ready && !stall;
        end else begin
            exp_ir = 1'b1;
        end
        if (reset)
            chk("reset_outputs", {cond_ex, pc_src_o, reg_write_o, mem_write_o}, 4'h0);
        chk("in_ready", {3'b0, in_ready}, {3'b0, exp_ir});
        if (exp_ov && out_ready && !reset) begin
            exp_committed = h.post;
            void'(sb.pop_front());
        end
    end

    initial begin : stim
        logic acc;
        // Reset held while an instruction is offered: nothing may enter.
        reset = 1'b1;
        cyc(1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        cyc(1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        reset = 1'b0;
        send(4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Full commit then EQ consumer.
        send(4'hE, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0);
        send(4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Partial update of N,Z only, then GE.
        send(4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0);
        send(4'hE, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(4'hA, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Failed condition suppresses writes and flag update.
        send(4'hE, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(4'h0, 2'b11, 4'b1000, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Hazard under backpressure: producer held 3 cycles, NE waiting.
        send(4'hE, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h1, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        send(4'h1, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);

        // Backpressure 4 cycles then same-cycle swap.
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'hE, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        send(4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Random traffic with a mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset = 1'b1;
                sb.delete();
                arch_flags = 4'h0;
                exp_committed = 4'h0;
                cyc(1'b1, 4'h0, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, acc);
                reset = 1'b0;
            end
            cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), acc);
        end
        idle(4);
        chk("drained", {3'b0, out_valid}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
